// File: rtl/multiword_add_sequencer.sv
// Multi-word unsigned adder that reuses one narrow ripple-carry adder, one CHUNK_W
// slice per clock (LSB first), with valid/ready handshakes on both sides.

module ripple_carry_adder #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_add_term1,
   input  logic [WIDTH-1:0] i_add_term2,
   output logic [WIDTH:0]   o_result
);

   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      logic p;
      assign p             = i_add_term1[g] ^ i_add_term2[g];
      assign o_result[g]   = p ^ carry[g];
      assign carry[g+1]    = (i_add_term1[g] & i_add_term2[g]) | (p & carry[g]);
   end

   assign o_result[WIDTH] = carry[WIDTH];

endmodule

// state    | meaning
// ST_IDLE  | waiting for an operand pair; o_ready high unless flushing
// ST_RUN   | adding slice idx_q, carry chained through carry_q
// ST_DONE  | o_sum complete, o_valid high until downstream takes it
module multiword_add_sequencer #(
   parameter int CHUNK_W  = 4,
   parameter int N_CHUNKS = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [CHUNK_W*N_CHUNKS-1:0]    i_operand_a,
   input  logic [CHUNK_W*N_CHUNKS-1:0]    i_operand_b,
   input  logic                           i_flush,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [CHUNK_W*N_CHUNKS:0]      o_sum
);

   localparam int OP_W  = CHUNK_W * N_CHUNKS;
   localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic [OP_W:0]    sum_q, sum_d;

   logic [CHUNK_W-1:0] a_slice;
   logic [CHUNK_W-1:0] b_slice;
   logic [CHUNK_W+1:0] add_res;
   logic [CHUNK_W-1:0] slice_sum;
   logic               slice_cout;
   logic               unused_lsb;

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int k = 0; k < N_CHUNKS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_slice = a_q[k*CHUNK_W +: CHUNK_W];
            b_slice = b_q[k*CHUNK_W +: CHUNK_W];
         end
      end
   end

   // The forced 1 in bit 0 turns carry_q into a carry-in at bit 1 of the adder.
   ripple_carry_adder #(
      .WIDTH (CHUNK_W + 1)
   ) u_adder (
      .i_add_term1 ({a_slice, 1'b1}),
      .i_add_term2 ({b_slice, carry_q}),
      .o_result    (add_res)
   );

   assign slice_sum  = add_res[CHUNK_W:1];
   assign slice_cout = add_res[CHUNK_W+1];
   assign unused_lsb = add_res[0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      if (i_flush) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         carry_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  a_d     = i_operand_a;
                  b_d     = i_operand_b;
                  sum_d   = '0;
                  carry_d = 1'b0;
                  idx_d   = '0;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               for (int k = 0; k < N_CHUNKS; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     sum_d[k*CHUNK_W +: CHUNK_W] = slice_sum;
                  end
               end
               carry_d = slice_cout;
               if (idx_q == IDX_LAST) begin
                  sum_d[OP_W] = slice_cout;
                  state_d     = ST_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   assign o_ready = (state_q == ST_IDLE) && !i_flush;
   assign o_valid = (state_q == ST_DONE);
   assign o_sum   = sum_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed and random checks of multiword_add_sequencer against plain integer addition.
module tb_multiword_add_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, valid, flush, rdy;
   logic [15:0] op_a, op_b;
   logic        ready_o, valid_o;
   logic [16:0] sum_o;

   logic        valid1, rdy1;
   logic [0:0]  a1, b1;
   logic        ready1_o, valid1_o;
   logic [1:0]  sum1_o;

   int checks = 0;
   int errors = 0;

   multiword_add_sequencer #(.CHUNK_W(4), .N_CHUNKS(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_o),
      .i_operand_a(op_a), .i_operand_b(op_b), .i_flush(flush),
      .o_valid(valid_o), .i_ready(rdy), .o_sum(sum_o)
   );

   multiword_add_sequencer #(.CHUNK_W(1), .N_CHUNKS(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .o_ready(ready1_o),
      .i_operand_a(a1), .i_operand_b(b1), .i_flush(1'b0),
      .o_valid(valid1_o), .i_ready(rdy1), .o_sum(sum1_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic accept(input logic [15:0] a, input logic [15:0] b);
      valid = 1'b1;
      op_a  = a;
      op_b  = b;
      tick();
      valid = 1'b0;
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
   endtask

   task automatic accept_and_wait(input string tag, input logic [15:0] a, input logic [15:0] b);
      int lat;
      logic [16:0] exp_sum;
      exp_sum = 17'(a) + 17'(b);
      chk({tag, "_ready"}, 32'(ready_o), 32'd1);
      accept(a, b);
      lat = 0;
      while (!valid_o && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_sum"}, 32'(sum_o), 32'(exp_sum));
   endtask

   task automatic release_result(input string tag);
      valid = 1'b0;
      rdy   = 1'b1;
      tick();
      rdy   = 1'b0;
      chk({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      logic [16:0] held;
      logic [15:0] ra, rb;
      int          bad;

      rst_n = 1'b0; valid = 1'b0; flush = 1'b0; rdy = 1'b0;
      op_a = '0; op_b = '0;
      valid1 = 1'b0; rdy1 = 1'b0; a1 = '0; b1 = '0;
      #1;
      chk("rst_sum", 32'(sum_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(ready_o), 32'd1);
      chk("post_rst_valid", 32'(valid_o), 32'd0);

      accept_and_wait("d1234", 16'h1234, 16'h0001);  release_result("d1234");
      accept_and_wait("dripple", 16'hFFFF, 16'h0001); release_result("dripple");
      accept_and_wait("dmax", 16'hFFFF, 16'hFFFF);    release_result("dmax");
      accept_and_wait("dzero", 16'h0000, 16'h0000);   release_result("dzero");

      // backpressure with i_valid pulsing in DONE
      accept_and_wait("bp", 16'hABCD, 16'h1111);
      held = sum_o;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         valid = ~valid;
         op_a  = 16'($urandom);
         op_b  = 16'($urandom);
         tick();
         if (!(valid_o === 1'b1 && sum_o === held && ready_o === 1'b0)) bad++;
      end
      chk("bp_hold", 32'(bad), 32'd0);
      release_result("bp");
      chk("bp_sum_after", 32'(sum_o), 32'h0BCDE);
      accept_and_wait("bp_next", 16'h0F0F, 16'h00F1); release_result("bp_next");

      // reset in RUN at idx 2
      accept(16'hFFFF, 16'h0001);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_sum", 32'(sum_o), 32'd0);
      chk("midrst_valid", 32'(valid_o), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      accept_and_wait("after_rst", 16'h0001, 16'h0001); release_result("after_rst");

      // flush in RUN at idx 1
      ra = 16'($urandom);
      rb = 16'($urandom);
      accept(ra, rb);
      tick();
      flush = 1'b1;
      #1;
      chk("flush_ready_low", 32'(ready_o), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_valid", 32'(valid_o), 32'd0);
      chk("flush_ready", 32'(ready_o), 32'd1);
      chk("flush_sum_kept", 32'(sum_o), 32'((17'(ra) + 17'(rb)) & 17'h0000F));
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (valid_o !== 1'b0) bad++;
      end
      chk("flush_no_valid", 32'(bad), 32'd0);

      // flush beats accept in IDLE
      valid = 1'b1;
      flush = 1'b1;
      op_a  = 16'h5555;
      op_b  = 16'h5555;
      #1;
      chk("flush_acc_ready", 32'(ready_o), 32'd0);
      tick();
      valid = 1'b0;
      flush = 1'b0;
      #1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (ready_o !== 1'b1 || valid_o !== 1'b0) bad++;
         tick();
      end
      chk("flush_no_accept", 32'(bad), 32'd0);

      // flush in DONE drops o_valid, keeps o_sum
      accept_and_wait("fdone", 16'h8000, 16'h8001);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("fdone_valid", 32'(valid_o), 32'd0);
      chk("fdone_sum", 32'(sum_o), 32'h10001);
      chk("fdone_ready", 32'(ready_o), 32'd1);

      for (int n = 0; n < 25; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         accept_and_wait("rand", ra, rb);
         release_result("rand");
      end

      for (int n = 0; n < 4; n++) begin
         a1     = 1'(n);
         b1     = 1'(n >> 1);
         chk("n1_ready", 32'(ready1_o), 32'd1);
         valid1 = 1'b1;
         tick();
         valid1 = 1'b0;
         chk("n1_busy", 32'(ready1_o), 32'd0);
         tick();
         chk("n1_valid", 32'(valid1_o), 32'd1);
         chk("n1_sum", 32'(sum1_o), 32'((n & 1) + ((n >> 1) & 1)));
         rdy1 = 1'b1;
         tick();
         rdy1 = 1'b0;
         chk("n1_release", 32'(valid1_o), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
